// File: rtl/seq_add_pkg.sv
// Shared constants and state encoding for the multi-word add sequencer.
package seq_add_pkg;

    localparam int CHUNK_W   = 16;  // width of the shared adder slice
    localparam int CHUNK_LG  = 4;   // log2(CHUNK_W), used to build chunk shift amounts
    localparam int MAX_WORDS = 8;   // largest legal WORDS
    localparam int IDX_W     = 3;   // clog2(MAX_WORDS), chunk index width

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/multiword_add_sequencer_slice.sv
// 16-bit two-level carry-lookahead adder: 4-bit groups with group
// generate/propagate feeding a second lookahead level. Purely combinational.
module AheadAdder16bit_module (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;

    // Bit and group generate/propagate, group carries, then per-bit carries.
    always_comb begin
        g  = a & b;
        p  = a ^ b;
        gg = '0;
        gp = '0;
        c  = '0;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
        gc[0] = cin;
        gc[1] = gg[0] | (gp[0] & cin);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & cin);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
        for (int k = 0; k < 4; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end
        sum  = p ^ c;
        cout = gc[4];
    end

endmodule

// File: rtl/multiword_add_sequencer.sv
// WORDS x 16-bit add (optionally subtract) computed one chunk per cycle on a
// single shared 16-bit lookahead slice, carry chained through a register.
// Optional feature macro: SEQ_ADD_SUB_EN (honour op_sub; default build adds only).
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_ready depends only on state (high in IDLE). out_valid, once
// high, holds with stable sum/flags until out_ready completes the transfer.
module multiword_add_sequencer
    import seq_add_pkg::*;
#(
    parameter  int WORDS = 4,
    localparam int W     = CHUNK_W * WORDS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         op_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         zero,
    output logic [1:0]   dbg_state
);

    seq_state_e          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                carry_q, carry_d;
    logic [W-1:0]        a_q, a_d;
    logic [W-1:0]        b_q, b_d;
    logic [W-1:0]        sum_q, sum_d;
    logic                cout_q, cout_d;
    logic                ovf_q, ovf_d;
    logic                zero_q, zero_d;
    logic                out_valid_q, out_valid_d;

    logic [IDX_W+CHUNK_LG-1:0] shamt;
    logic [CHUNK_W-1:0]        slice_a;
    logic [CHUNK_W-1:0]        slice_b;
    logic [CHUNK_W-1:0]        slice_s;
    logic                      slice_co;
    logic [W-1:0]              chunk_mask;

`ifndef SEQ_ADD_SUB_EN
    // Add-only build: op_sub is a dangling port.
    logic unused_op_sub;
    assign unused_op_sub = op_sub;
`endif

    assign shamt      = {idx_q, {CHUNK_LG{1'b0}}};
    assign chunk_mask = W'({CHUNK_W{1'b1}});
    assign slice_a    = CHUNK_W'(a_q >> shamt);
    assign slice_b    = CHUNK_W'(b_q >> shamt);

    AheadAdder16bit_module u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_s),
        .cout (slice_co)
    );

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign dbg_state = state_q;

    // Next-state: accept in IDLE, one chunk per cycle in RUN, hold in DONE.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d   = op_a;
`ifdef SEQ_ADD_SUB_EN
                    b_d     = op_sub ? ~op_b : op_b;
                    carry_d = op_sub;
`else
                    b_d     = op_b;
                    carry_d = 1'b0;
`endif
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d   = (sum_q & ~(chunk_mask << shamt)) | (W'(slice_s) << shamt);
                carry_d = slice_co;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDX_W'(WORDS - 1)) begin
                    idx_d       = '0;
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    cout_d      = slice_co;
                    zero_d      = (sum_d == '0);
                    ovf_d       = (a_q[W-1] == b_q[W-1]) && (sum_d[W-1] != a_q[W-1]);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed testbench for multiword_add_sequencer (WORDS=4, 64-bit operands).
module tb_multiword_add_sequencer;

    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic [1:0]   dbg_state;

    int errors = 0;
    int checks = 0;

    multiword_add_sequencer #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Driver: present one operation, wait for acceptance, then wait for
    // out_valid. lat counts edges from acceptance to out_valid (99 = timeout).
    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic sub, output int lat);
        int waitc;
        @(negedge clk);
        waitc = 0;
        while (!in_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        op_sub   = sub;
        @(negedge clk);
        in_valid = 1'b0;
        op_a     = {$urandom, $urandom};
        op_b     = {$urandom, $urandom};
        op_sub   = 1'($urandom_range(0, 1));
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = 99;
    endtask

    // Driver: complete the output handshake.
    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_sub    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b state=%0d, expected 1 0 0",
                     in_ready, out_valid, dbg_state);
        end
        checks++;
        if (sum !== '0 || cout !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: sum=%h cout=%b ovf=%b zero=%b, expected all 0",
                     sum, cout, ovf, zero);
        end
    endtask

    task automatic test_chunk_carry();
        int lat;
        drive_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL chunk_carry_latency: got %0d cycles, expected 4", lat);
        end
        checks++;
        if (sum !== 64'h0000_0000_0001_0000 || cout !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL chunk_carry: sum=%h c=%b v=%b z=%b, expected 0000000000010000 0 0 0",
                     sum, cout, ovf, zero);
        end
        consume();
    endtask

    task automatic test_full_ripple();
        int lat;
        drive_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL ripple_latency: got %0d cycles, expected 4", lat);
        end
        checks++;
        if (sum !== 64'h0 || cout !== 1'b1 || ovf !== 1'b0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL full_ripple: sum=%h c=%b v=%b z=%b, expected 0 1 0 1",
                     sum, cout, ovf, zero);
        end
        consume();
    endtask

    task automatic test_overflow();
        int lat;
        drive_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat);
        checks++;
        if (sum !== 64'h8000_0000_0000_0000 || cout !== 1'b0 || ovf !== 1'b1 || zero !== 1'b0) begin
            errors++;
            $display("FAIL overflow: sum=%h c=%b v=%b z=%b, expected 8000000000000000 0 1 0",
                     sum, cout, ovf, zero);
        end
        consume();
    endtask

    task automatic test_sub();
        int lat;
        logic [W-1:0] exp_sum;
`ifdef SEQ_ADD_SUB_EN
        exp_sum = 64'hFFFF_FFFF_FFFF_FFFE;
`else
        exp_sum = 64'd12;
`endif
        drive_op(64'd5, 64'd7, 1'b1, lat);
        checks++;
        if (sum !== exp_sum || cout !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL sub_5_7: sum=%h c=%b v=%b z=%b, expected %h 0 0 0",
                     sum, cout, ovf, zero, exp_sum);
        end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [W-1:0] exp_sum;
        exp_sum = 64'h1001_2002_3003_4004;
        drive_op(64'h0001_0002_0003_0004, 64'h1000_2000_3000_4000, 1'b0, lat);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            op_a     = 64'hDEAD_BEEF_0000_0001 + 64'(i);
            op_b     = 64'h1234_5678_9ABC_DEF0;
            @(negedge clk);
            checks++;
            if (sum !== exp_sum || cout !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: sum=%h c=%b ov=%b ir=%b, expected %h 0 1 0",
                         i, sum, cout, out_valid, in_ready, exp_sum);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL release_idle: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
        end
        in_valid = 1'b1;
        op_a     = 64'h0000_0000_0000_0010;
        op_b     = 64'h0000_0000_0000_0020;
        op_sub   = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (dbg_state !== 2'd1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL next_accept: state=%0d in_ready=%b, expected 1 0", dbg_state, in_ready);
        end
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 4 || sum !== 64'h30) begin
            errors++;
            $display("FAIL next_result: lat=%0d sum=%h, expected 4 0000000000000030", lat, sum);
        end
        consume();
    endtask

    task automatic test_mid_run_reset();
        int lat;
        int seen;
        @(negedge clk);
        in_valid = 1'b1;
        op_a     = 64'h1111_1111_1111_1111;
        op_b     = 64'h2222_2222_2222_2222;
        op_sub   = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (dbg_state !== 2'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrun_ctrl: state=%0d in_ready=%b out_valid=%b, expected 0 1 0",
                     dbg_state, in_ready, out_valid);
        end
        checks++;
        if (sum !== '0 || cout !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL midrun_data: sum=%h c=%b v=%b z=%b, expected all 0", sum, cout, ovf, zero);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midrun_no_valid: out_valid cycles=%0d, expected 0", seen);
        end
        drive_op(64'd1, 64'd2, 1'b0, lat);
        checks++;
        if (lat !== 4 || sum !== 64'd3) begin
            errors++;
            $display("FAIL post_reset_op: lat=%0d sum=%h, expected 4 0000000000000003", lat, sum);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_chunk_carry();
        test_full_ripple();
        test_overflow();
        test_sub();
        test_backpressure();
        test_mid_run_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
